// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    LOCK = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
  } disp_frame_t;

  localparam logic [3:0] DP_ALL_ON = 4'b1111;

  // (base + off) mod n, for base < n and off <= n.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/sevenseg_rr_pick.sv
// Round-robin picker: first valid index strictly after start_idx, wrapping,
// with start_idx itself as the last candidate.
module sevenseg_rr_pick
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [IDX_W-1:0]   start_idx,
  output logic [IDX_W-1:0]   next_idx_c,
  output logic               found_c
);

  // Scan farthest-first so the nearest valid candidate wins.
  always_comb begin
    next_idx_c = start_idx;
    found_c    = 1'b0;
    for (int unsigned k = NUM_SRC; k > 0; k--) begin
      if (valid[IDX_W'(wrap_idx(32'(start_idx), k, NUM_SRC))]) begin
        next_idx_c = IDX_W'(wrap_idx(32'(start_idx), k, NUM_SRC));
        found_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_scheduler.sv
// Round-robin sharing of the 4-digit seven-segment display between requesters.
// Optional DP blink while locked: define SEVENSEG_SCHED_BLINK_EN.
module sevenseg_scheduler
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC-1:0][15:0]     src_value,
  input  logic [NUM_SRC-1:0][3:0]      src_dp,
  input  logic                         lock_req,
  output logic [15:0]                  disp_value,
  output logic [3:0]                   disp_dp,
  output logic                         disp_blank,
  output logic [$clog2(NUM_SRC)-1:0]   cur_src,
  output logic [NUM_SRC-1:0]           src_ack
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  // Elaboration-time parameter sanity.
  if (NUM_SRC < 2) begin : g_bad_num_src
    $error("sevenseg_scheduler: NUM_SRC must be >= 2");
  end
  if (DWELL_CYCLES < 2) begin : g_bad_dwell
    $error("sevenseg_scheduler: DWELL_CYCLES must be >= 2");
  end
  if (BLINK_CYCLES < 1) begin : g_bad_blink
    $error("sevenseg_scheduler: BLINK_CYCLES must be >= 1");
  end

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   cur_src_q, cur_src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  disp_frame_t        frame_q, frame_d;
  logic               blank_q, blank_d;

  logic [IDX_W-1:0]   pick_start;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               dp_force_c;

  // From IDLE start the search just below index 0 so the lowest valid wins.
  assign pick_start = (state_q == IDLE) ? IDX_W'(NUM_SRC - 1) : cur_src_q;

  sevenseg_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid      (src_valid),
    .start_idx  (pick_start),
    .next_idx_c (pick_idx),
    .found_c    (pick_found)
  );

  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d   = SHOW;
          cur_src_d = pick_idx;
          ack_d     = NUM_SRC'(1) << pick_idx;
          cnt_d     = '0;
        end
      end
      SHOW, LOCK: begin
        if (!src_valid[cur_src_q]) begin
          // Shown source withdrew: move on regardless of lock.
          cnt_d = '0;
          if (pick_found) begin
            state_d   = SHOW;
            cur_src_d = pick_idx;
            ack_d     = NUM_SRC'(1) << pick_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (state_q == LOCK) begin
          if (!lock_req) begin
            state_d = SHOW;
          end
        end else if (lock_req) begin
          state_d = LOCK;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          cur_src_d = pick_idx;
          if (pick_idx != cur_src_q) begin
            ack_d = NUM_SRC'(1) << pick_idx;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef SEVENSEG_SCHED_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;

  // Half-period timer, restarted (DPs shown as-is) on every LOCK entry.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if ((state_d != LOCK) || (state_q != LOCK)) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = !blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign dp_force_c = blink_on_d && (state_d == LOCK);
`else
  assign dp_force_c = 1'b0;
`endif

  // Display frame follows the next selection so it lines up with cur_src.
  always_comb begin
    frame_d = '0;
    blank_d = (state_d == IDLE);
    if (state_d != IDLE) begin
      frame_d.value = src_value[cur_src_d];
      frame_d.dp    = dp_force_c ? DP_ALL_ON : src_dp[cur_src_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_src_q <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      frame_q   <= '0;
      blank_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      frame_q   <= frame_d;
      blank_q   <= blank_d;
    end
  end

  assign disp_value = frame_q.value;
  assign disp_dp    = frame_q.dp;
  assign disp_blank = blank_q;
  assign cur_src    = cur_src_q;
  assign src_ack    = ack_q;

endmodule

// File: tb/tb_sevenseg_scheduler.sv
// Self-checking bench for sevenseg_scheduler (NUM_SRC=4, DWELL=8, BLINK=3).
module tb_sevenseg_scheduler;

  localparam int NSRC  = 4;
  localparam int DWELL = 8;
  localparam int BLINK = 3;

  logic             clk;
  logic             reset;
  logic [3:0]       src_valid;
  logic [3:0][15:0] src_value;
  logic [3:0][3:0]  src_dp;
  logic             lock_req;
  logic [15:0]      disp_value;
  logic [3:0]       disp_dp;
  logic             disp_blank;
  logic [1:0]       cur_src;
  logic [3:0]       src_ack;

  sevenseg_scheduler #(
    .NUM_SRC      (NSRC),
    .DWELL_CYCLES (DWELL),
    .BLINK_CYCLES (BLINK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_value  (src_value),
    .src_dp     (src_dp),
    .lock_req   (lock_req),
    .disp_value (disp_value),
    .disp_dp    (disp_dp),
    .disp_blank (disp_blank),
    .cur_src    (cur_src),
    .src_ack    (src_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: mode 0=idle, 1=show, 2=lock; m_left = dwell cycles remaining.
  int         m_mode, m_src, m_left, m_lockt;
  logic [3:0] m_ack;

  function automatic int next_valid(input logic [3:0] mask, input int from);
    for (int k = 1; k <= NSRC; k++) begin
      int i;
      i = (from + k) % NSRC;
      if (mask[i]) return i;
    end
    return from;
  endfunction

  task automatic model_update();
    int n;
    m_ack = '0;
    if (reset) begin
      m_mode = 0; m_src = 0; m_left = DWELL; m_lockt = 0;
    end else if (m_mode == 0) begin
      if (src_valid != 0) begin
        m_src = next_valid(src_valid, NSRC - 1);
        m_mode = 1; m_left = DWELL; m_ack = 4'b0001 << m_src;
      end
    end else if (!src_valid[m_src]) begin
      if (src_valid == 0) m_mode = 0;
      else begin
        m_src = next_valid(src_valid, m_src);
        m_mode = 1; m_left = DWELL; m_ack = 4'b0001 << m_src;
      end
    end else if (m_mode == 2) begin
      if (!lock_req) m_mode = 1;
      else m_lockt++;
    end else if (lock_req) begin
      m_mode = 2; m_lockt = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        n = next_valid(src_valid, m_src);
        if (n != m_src) m_ack = 4'b0001 << n;
        m_src = n; m_left = DWELL;
      end
    end
  endtask

  function automatic logic [3:0] exp_dp();
    if (m_mode == 0) return 4'h0;
`ifdef SEVENSEG_SCHED_BLINK_EN
    if (m_mode == 2 && ((m_lockt / BLINK) % 2) == 1) return 4'hF;
`endif
    return src_dp[m_src];
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("cur_src", 32'(cur_src), 32'(m_src));
    chk("src_ack", 32'(src_ack), 32'(m_ack));
    chk("disp_blank", 32'(disp_blank), 32'(m_mode == 0));
    chk("disp_value", 32'(disp_value), (m_mode == 0) ? 32'h0 : 32'(src_value[m_src]));
    chk("disp_dp", 32'(disp_dp), 32'(exp_dp()));
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       lock;
    int         cycles;
    int         exp_src;
    logic       exp_blank;
  } vec_t;

  vec_t       tbl[8];
  logic [3:0] dp_exp[6];
  int         ack_cnt;

  initial begin
    tbl[0] = '{4'b1011, 1'b0, 1,  0, 1'b0};
    tbl[1] = '{4'b1011, 1'b0, 8,  1, 1'b0};
    tbl[2] = '{4'b1011, 1'b0, 8,  3, 1'b0};
    tbl[3] = '{4'b1011, 1'b1, 20, 3, 1'b0};
    tbl[4] = '{4'b1011, 1'b0, 9,  0, 1'b0};
    tbl[5] = '{4'b0001, 1'b0, 1,  0, 1'b0};
    tbl[6] = '{4'b0000, 1'b0, 1,  0, 1'b1};
    tbl[7] = '{4'b0100, 1'b0, 1,  2, 1'b0};

    reset = 1'b1; lock_req = 1'b0; src_valid = '0;
    src_value[0] = 16'h1111; src_value[1] = 16'h2222;
    src_value[2] = 16'h0000; src_value[3] = 16'h4444;
    src_dp[0] = 4'b1000; src_dp[1] = 4'b0100; src_dp[2] = 4'b0010; src_dp[3] = 4'b0001;
    step(); step();
    reset = 1'b0;
    chk("rst_cur_src", 32'(cur_src), 32'h0);
    chk("rst_ack", 32'(src_ack), 32'h0);
    chk("rst_blank", 32'(disp_blank), 32'h1);
    chk("rst_value", 32'(disp_value), 32'h0);
    chk("rst_dp", 32'(disp_dp), 32'h0);

    // Table-driven phases.
    for (int r = 0; r < 8; r++) begin
      src_valid = tbl[r].valid;
      lock_req  = tbl[r].lock;
      for (int c = 0; c < tbl[r].cycles; c++) step();
      chk($sformatf("tbl%0d_src", r), 32'(cur_src), 32'(tbl[r].exp_src));
      chk($sformatf("tbl%0d_blank", r), 32'(disp_blank), 32'(tbl[r].exp_blank));
    end
    lock_req = 1'b0; reset = 1'b1; step(); reset = 1'b0;

    // Rotation over 0,1,3 with acks.
    src_valid = 4'b1011;
    step();
    chk("t1_src0", 32'(cur_src), 32'h0); chk("t1_ack0", 32'(src_ack), 32'h1);
    chk("t1_val0", 32'(disp_value), 32'h1111);
    repeat (7) step();
    chk("t1_hold0", 32'(cur_src), 32'h0);
    step();
    chk("t1_src1", 32'(cur_src), 32'h1); chk("t1_ack1", 32'(src_ack), 32'h2);
    repeat (8) step();
    chk("t1_src3", 32'(cur_src), 32'h3); chk("t1_ack3", 32'(src_ack), 32'h8);
    repeat (8) step();
    chk("t1_wrap0", 32'(cur_src), 32'h0); chk("t1_ackw", 32'(src_ack), 32'h1);

    // Single source: one ack, live value.
    src_valid = 4'b0100;
    step();
    chk("t2_src", 32'(cur_src), 32'h2); chk("t2_ack", 32'(src_ack), 32'h4);
    ack_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (src_ack != 0) ack_cnt++;
    end
    chk("t2_no_more_acks", 32'(ack_cnt), 32'h0);
    chk("t2_still2", 32'(cur_src), 32'h2);
    src_value[2] = 16'h3333;
    step();
    chk("t2_live", 32'(disp_value), 32'h3333);

    // Lock holds source 1, then remaining dwell only.
    src_valid = 4'b0010;
    step();
    chk("t3_src1", 32'(cur_src), 32'h1); chk("t3_ack1", 32'(src_ack), 32'h2);
    src_valid = 4'b1011;
    step(); step();
    lock_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t3_locked", 32'(cur_src), 32'h1);
    end
    lock_req = 1'b0;
    step();
    repeat (5) step();
    chk("t3_remain", 32'(cur_src), 32'h1);
    step();
    chk("t3_next", 32'(cur_src), 32'h3); chk("t3_ack", 32'(src_ack), 32'h8);

    // Drop of shown source wraps to 0, then all drop -> idle.
    repeat (3) step();
    src_valid = 4'b0011;
    step();
    chk("t4_wrap", 32'(cur_src), 32'h0); chk("t4_ack", 32'(src_ack), 32'h1);
    src_valid = 4'b0000;
    step();
    chk("t4_blank", 32'(disp_blank), 32'h1); chk("t4_value", 32'(disp_value), 32'h0);

    // Reset while locked.
    src_valid = 4'b0010;
    step();
    lock_req = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    chk("t5_blank", 32'(disp_blank), 32'h1); chk("t5_src", 32'(cur_src), 32'h0);
    chk("t5_ack", 32'(src_ack), 32'h0);
    reset = 1'b0; lock_req = 1'b0; src_valid = 4'b0000;
    step();
    chk("t5_idle", 32'(disp_blank), 32'h1);

    // DP during lock.
`ifdef SEVENSEG_SCHED_BLINK_EN
    dp_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b1111, 4'b1111, 4'b1111};
`else
    dp_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    src_dp[1] = 4'b0001;
    src_valid = 4'b0010;
    step();
    lock_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t6_dp%0d", i), 32'(disp_dp), 32'(dp_exp[i]));
    end
    lock_req = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(499) == 0);
      if ($urandom_range(15) == 0) src_valid = 4'($urandom);
      if ($urandom_range(9) == 0) lock_req = ~lock_req;
      if ($urandom_range(3) == 0) src_value[$urandom_range(3)] = 16'($urandom);
      if ($urandom_range(7) == 0) src_dp[$urandom_range(3)] = 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
